if_fetch_buf: RTL

- Parametrised next-generation instruction-fetch stage with a DEPTH-entry prefetch buffer between the icache and the instruction queue.
- Keeps one icache request outstanding and runs ahead of the decoder until the buffer is full.
- Handles ROB-cleaner redirects and dispatcher branch-prediction redirects by flushing the buffer and discarding the in-flight response.
- Delivers {pc, inst} to the iqueue over a valid/ready handshake.

---
 rtl/if_fetch_buf_pkg.sv | 24 ++
 rtl/if_fetch_buf_fetch_fifo.sv | 54 +++++
 rtl/if_fetch_buf.sv | 113 +++++++++++
 3 files changed

// File: rtl/if_fetch_buf_pkg.sv
// Shared defaults and types for the instruction-fetch prefetch stage.
// Widths here are defaults; the top and the buffer take them as overridable parameters.
package if_fetch_buf_pkg;

    localparam int unsigned DefAddrW     = 32;
    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefDepth     = 4;
    localparam int unsigned DefInstBytes = 4;
    localparam logic [DefAddrW-1:0] DefResetPc = '0;

    // Which source drives the next fetch address, highest priority last.
    typedef enum logic [1:0] {
        SrcHold,
        SrcAccept,
        SrcBrPred,
        SrcNew
    } addr_src_e;

    // A buffer entry is {pc, inst}.
    function automatic int unsigned entry_w(int unsigned addr_w, int unsigned data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/if_fetch_buf_fetch_fifo.sv
// Prefetch storage: DEPTH entries with push, pop, flush and a combinational head.
// Callers gate push/pop/flush with the global enable so the buffer freezes with the pipe.
module if_fetch_buf_fetch_fifo
    import if_fetch_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned WIDTH = entry_w(DefAddrW, DefDataW)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  head_ptr;
    logic [PtrW-1:0]  tail_ptr;
    logic [CntW-1:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                mem[tail_ptr] <= wdata;
                tail_ptr      <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            cnt <= cnt + CntW'(push) - CntW'(pop);
        end
    end

    assign head  = mem[head_ptr];
    assign count = cnt;

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: one outstanding icache request running ahead into a prefetch
// buffer, with ROB-cleaner and branch-prediction redirects that flush and re-target.
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DefAddrW,
    parameter int unsigned       DATA_W     = DefDataW,
    parameter int unsigned       DEPTH      = DefDepth,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DefResetPc),
    parameter int unsigned       INST_BYTES = DefInstBytes
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,

    output logic                     icache_en_o,
    output logic [ADDR_W-1:0]        icache_addr_o,
    input  logic                     icache_rdy_i,
    input  logic [DATA_W-1:0]        icache_data_i,

    output logic                     iq_valid_o,
    input  logic                     iq_ready_i,
    output logic [DATA_W-1:0]        iq_data_o,
    output logic [ADDR_W-1:0]        iq_pc_o,

    input  logic                     new_en_i,
    input  logic [ADDR_W-1:0]        new_pc_i,
    input  logic                     br_pred_en_i,
    input  logic [ADDR_W-1:0]        br_pred_pc_i,

    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int unsigned OccW    = $clog2(DEPTH) + 1;
    localparam int unsigned EntryW  = entry_w(ADDR_W, DATA_W);
    // Redirect targets are forced onto an instruction boundary.
    localparam logic [ADDR_W-1:0] AlignMask = ~(ADDR_W'(INST_BYTES) - ADDR_W'(1));

    logic              en_q, en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    addr_src_e         src;
    logic              redirect;
    logic              push, pop, flush;
    logic [OccW-1:0]   occ, occ_next;
    logic [EntryW-1:0] head;

    always_comb begin
        src = SrcHold;
        if (new_en_i) begin
            src = SrcNew;
        end else if (br_pred_en_i) begin
            src = SrcBrPred;
        end else if (en_q && icache_rdy_i) begin
            src = SrcAccept;
        end
    end

    assign redirect = (src == SrcNew) || (src == SrcBrPred);
    assign flush    = rdy && redirect;
    assign push     = rdy && (src == SrcAccept);
    // A redirect voids any pop offered in the same cycle.
    assign pop      = rdy && !redirect && iq_valid_o && iq_ready_i;
    assign occ_next = occ + OccW'(push) - OccW'(pop);

    always_comb begin
        addr_d = addr_q;
        en_d   = occ_next < OccW'(DEPTH);
        unique case (src)
            SrcNew: begin
                addr_d = new_pc_i & AlignMask;
                en_d   = 1'b1;
            end
            SrcBrPred: begin
                addr_d = br_pred_pc_i & AlignMask;
                en_d   = 1'b1;
            end
            SrcAccept: addr_d = addr_q + ADDR_W'(INST_BYTES);
            SrcHold:   addr_d = addr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            addr_q <= RESET_PC;
        end else if (rdy) begin
            en_q   <= en_d;
            addr_q <= addr_d;
        end
    end

    if_fetch_buf_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({addr_q, icache_data_i}),
        .head  (head),
        .count (occ)
    );

    assign icache_en_o   = en_q;
    assign icache_addr_o = addr_q;
    assign iq_valid_o    = occ != '0;
    assign iq_pc_o       = head[EntryW-1:DATA_W];
    assign iq_data_o     = head[DATA_W-1:0];
    assign occupancy_o   = occ;

endmodule
